// File: rtl/onehot_stretch_pkg.sv
// Shared constants and helpers for the one-hot pulse stretcher.
package onehot_stretch_pkg;

    localparam int N_OUT_DEF  = 10;
    localparam int IDX_W_DEF  = 4;
    localparam int HOLD_W_DEF = 4;
    localparam int ERR_CNT_W  = 8;

    // A zero hold length still produces a one-cycle pulse.
    function automatic int unsigned hold_at_least_one(input int unsigned len);
        int unsigned res;
        if (len == 32'd0) begin
            res = 32'd1;
        end else begin
            res = len;
        end
        return res;
    endfunction

endpackage

// File: rtl/onehot_stretch_chan.sv
// One stretch channel: a down-counter whose non-zero state is the output pulse.
module stretch_chan
    import onehot_stretch_pkg::*;
#(
    parameter int HOLD_W = HOLD_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              hit,
    input  logic              retrig,
    input  logic [HOLD_W-1:0] hold_len,
    output logic              active_d,
    output logic              data_q
);

    logic [HOLD_W-1:0] cnt_d;
    logic [HOLD_W-1:0] cnt_q;
    logic [HOLD_W-1:0] load_val_s;

    assign load_val_s = HOLD_W'(hold_at_least_one(32'(hold_len)));

    // Next count: clear wins, then an accepted hit loads, otherwise count down.
    always_comb begin
        cnt_d    = cnt_q;
        active_d = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (hit && ((cnt_q <= HOLD_W'(1)) || retrig)) begin
            // A channel on its final cycle always accepts, giving seamless back-to-back pulses.
            cnt_d = load_val_s;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - HOLD_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        active_d = (cnt_d != '0);
    end

    // Counter and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            data_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            data_q <= active_d;
        end
    end

endmodule

// File: rtl/onehot_stretch.sv
// Index-to-one-hot decoder with per-channel programmable pulse stretching.
// Optional ONEHOT_STRETCH_ERR_EN adds err_flag/err_cnt for out-of-range strobes.
module onehot_stretch
    import onehot_stretch_pkg::*;
#(
    parameter int N_OUT  = N_OUT_DEF,
    parameter int IDX_W  = IDX_W_DEF,
    parameter int HOLD_W = HOLD_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [IDX_W-1:0]  idx_in,
    input  logic [HOLD_W-1:0] hold_len,
    input  logic              retrig,
    input  logic              clear,
    output logic [N_OUT-1:0]  data_out,
    output logic              busy
`ifdef ONEHOT_STRETCH_ERR_EN
    ,
    output logic                 err_flag,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    logic             in_range_s;
    logic [N_OUT-1:0] hit_vec_s;
    logic [N_OUT-1:0] active_d;
    logic             busy_d;
    logic             busy_q;

    assign in_range_s = (32'(idx_in) < N_OUT);

    // Index decode into a single-hot hit vector.
    always_comb begin
        hit_vec_s = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (enable && in_range_s && (idx_in == IDX_W'(i))) begin
                hit_vec_s[i] = 1'b1;
            end else begin
                hit_vec_s[i] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_chan
        stretch_chan #(
            .HOLD_W (HOLD_W)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear    (clear),
            .hit      (hit_vec_s[g]),
            .retrig   (retrig),
            .hold_len (hold_len),
            .active_d (active_d[g]),
            .data_q   (data_out[g])
        );
    end

    // busy is built from the channels' next state so it lines up with data_out.
    always_comb begin
        busy_d = |active_d;
    end

    // busy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

`ifdef ONEHOT_STRETCH_ERR_EN
    logic                 err_flag_d;
    logic                 err_flag_q;
    logic [ERR_CNT_W-1:0] err_cnt_d;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic                 oor_s;

    assign oor_s = enable && !in_range_s;

    // Sticky flag and saturating counter of out-of-range strobes.
    always_comb begin
        err_flag_d = err_flag_q;
        err_cnt_d  = err_cnt_q;
        if (clear) begin
            err_flag_d = 1'b0;
            err_cnt_d  = '0;
        end else if (oor_s) begin
            err_flag_d = 1'b1;
            if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end else begin
                err_cnt_d = err_cnt_q;
            end
        end else begin
            err_flag_d = err_flag_q;
            err_cnt_d  = err_cnt_q;
        end
    end

    // Error state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            err_flag_q <= err_flag_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign err_flag = err_flag_q;
    assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_onehot_stretch.sv
// Randomised self-checking bench for onehot_stretch using a pulse-end-time reference model.
module tb_onehot_stretch;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [3:0] idx_in;
    logic [3:0] hold_len;
    logic       retrig;
    logic       clear;
    logic [9:0] data_out;
    logic       busy;
`ifdef ONEHOT_STRETCH_ERR_EN
    logic       err_flag;
    logic [7:0] err_cnt;
`endif

    int n_checks;
    int n_fail;

    // Model: channel i is high in the cycle after edge t iff last_high[i] >= t.
    int edge_no;
    int last_high [10];
    int err_n;
    bit err_f;

    onehot_stretch u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .idx_in   (idx_in),
        .hold_len (hold_len),
        .retrig   (retrig),
        .clear    (clear),
        .data_out (data_out),
        .busy     (busy)
`ifdef ONEHOT_STRETCH_ERR_EN
        ,
        .err_flag (err_flag),
        .err_cnt  (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, edge_no);
        end
    endtask

    function automatic logic [9:0] model_out();
        logic [9:0] v;
        for (int i = 0; i < 10; i++) begin
            v[i] = (last_high[i] >= edge_no);
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 10; i++) begin
            last_high[i] = -1;
        end
        err_n = 0;
        err_f = 1'b0;
    endtask

    // One clock: drive inputs, update the model at the edge, compare on the falling edge.
    task automatic cycle(input bit en, input int idx, input int len, input bit rt, input bit clr);
        logic [9:0] exp_v;
        enable   = en;
        idx_in   = 4'(idx);
        hold_len = 4'(len);
        retrig   = rt;
        clear    = clr;
        @(posedge clk);
        edge_no++;
        if (clr) begin
            for (int i = 0; i < 10; i++) begin
                last_high[i] = edge_no - 1;
            end
            err_n = 0;
            err_f = 1'b0;
        end else if (en) begin
            if (idx < 10) begin
                if (last_high[idx] < edge_no || rt) begin
                    last_high[idx] = edge_no + ((len == 0) ? 1 : len) - 1;
                end
            end else begin
                err_f = 1'b1;
                if (err_n < 255) err_n++;
            end
        end
        @(negedge clk);
        exp_v = model_out();
        check_eq("data_out", 64'(data_out), 64'(exp_v));
        check_eq("busy", 64'(busy), 64'(|exp_v));
`ifdef ONEHOT_STRETCH_ERR_EN
        check_eq("err_flag", 64'(err_flag), 64'(err_f));
        check_eq("err_cnt", 64'(err_cnt), 64'(err_n));
`endif
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            cycle(1'b0, 0, 0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        edge_no  = 0;
        model_reset();
        rst_n    = 1'b0;
        enable   = 1'b0;
        idx_in   = 4'd0;
        hold_len = 4'd0;
        retrig   = 1'b0;
        clear    = 1'b0;
        #23;
        check_eq("reset_data", 64'(data_out), 64'd0);
        check_eq("reset_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Lone hit on channel 3, three cycles.
        cycle(1'b1, 3, 3, 1'b0, 1'b0);
        check_eq("lone_first", 64'(data_out), 64'h008);
        idle(4);

        // Channels 0 and 9 on consecutive cycles.
        cycle(1'b1, 0, 3, 1'b0, 1'b0);
        cycle(1'b1, 9, 3, 1'b0, 1'b0);
        check_eq("two_chan", 64'(data_out), 64'h201);
        idle(4);

        // Retrigger on channel 5, with and without reload.
        cycle(1'b1, 5, 4, 1'b1, 1'b0);
        idle(1);
        cycle(1'b1, 5, 4, 1'b1, 1'b0);
        idle(6);
        cycle(1'b1, 5, 4, 1'b0, 1'b0);
        idle(1);
        cycle(1'b1, 5, 4, 1'b0, 1'b0);
        idle(6);

        // Zero and maximum hold lengths, then period-15 rehits.
        cycle(1'b1, 2, 0, 1'b0, 1'b0);
        idle(2);
        cycle(1'b1, 7, 15, 1'b0, 1'b0);
        idle(16);
        for (int r = 0; r < 4; r++) begin
            cycle(1'b1, 4, 15, 1'b0, 1'b0);
            idle(14);
        end
        idle(2);

        // Clear beats a simultaneous hit while channels are active.
        cycle(1'b1, 1, 8, 1'b0, 1'b0);
        cycle(1'b1, 6, 8, 1'b0, 1'b0);
        cycle(1'b1, 8, 8, 1'b0, 1'b1);
        check_eq("clear_hit", 64'(data_out), 64'd0);
        idle(3);

        // Out-of-range indices leave outputs alone.
        cycle(1'b1, 3, 6, 1'b0, 1'b0);
        cycle(1'b1, 12, 6, 1'b0, 1'b0);
        cycle(1'b1, 15, 6, 1'b0, 1'b0);
        idle(6);
`ifdef ONEHOT_STRETCH_ERR_EN
        check_eq("err_cnt_two", 64'(err_cnt), 64'd2);
        for (int r = 0; r < 300; r++) begin
            cycle(1'b1, 10 + (r % 6), 3, 1'b0, 1'b0);
        end
        check_eq("err_cnt_sat", 64'(err_cnt), 64'd255);
        cycle(1'b0, 0, 0, 1'b0, 1'b1);
`endif

        // Asynchronous reset in the middle of a pulse.
        cycle(1'b1, 9, 10, 1'b0, 1'b0);
        idle(2);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_data", 64'(data_out), 64'd0);
        check_eq("async_rst_busy", 64'(busy), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Random traffic.
        for (int r = 0; r < 3000; r++) begin
            cycle(($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0,
                  int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)),
                  1'(($urandom >> 3) & 32'd1),
                  ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
        end
        idle(17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
